// File: rtl/adder64_error_checker_if.sv
// Bus bundle between the duplicated adder datapath and the error checker.
// Optional log outputs are present only when ERR_LOG_EN is defined.
interface adder64_error_checker_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_invert;
  logic             papb;
  logic             pab;
  logic             clear;
  logic             err_valid;
  logic             err_dup;
  logic             err_par;
  logic [CNT_W-1:0] err_cnt;
  logic             alarm;
`ifdef ERR_LOG_EN
  logic             log_valid;
  logic [WIDTH-1:0] log_s;
  logic [1:0]       log_syn;

  modport master (
    output in_valid, s, s_invert, papb, pab, clear,
    input  err_valid, err_dup, err_par, err_cnt, alarm, log_valid, log_s, log_syn
  );
  modport slave (
    input  in_valid, s, s_invert, papb, pab, clear,
    output err_valid, err_dup, err_par, err_cnt, alarm, log_valid, log_s, log_syn
  );
`else
  modport master (
    output in_valid, s, s_invert, papb, pab, clear,
    input  err_valid, err_dup, err_par, err_cnt, alarm
  );
  modport slave (
    input  in_valid, s, s_invert, papb, pab, clear,
    output err_valid, err_dup, err_par, err_cnt, alarm
  );
`endif
endinterface

// File: rtl/adder64_error_checker.sv
// Two-stage fault monitor for the duplicated carry-select adder: rail/parity checks,
// saturating error counter and sticky alarm FSM. ERR_LOG_EN adds a first-error log.
module adder64_error_checker #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ALARM_TH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adder64_error_checker_if.slave  bus
);

  typedef enum logic {MON, ALARM} state_e;

  localparam logic [CNT_W-1:0] TH      = CNT_W'(ALARM_TH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             v1_q;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] sinv1_q;
  logic             papb1_q;
  logic             pab1_q;

  logic             ev_q;
  logic             dup_q;
  logic             par_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;

  logic             dup1;
  logic             par1;
  logic             err1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      s1_q    <= '0;
      sinv1_q <= '0;
      papb1_q <= 1'b0;
      pab1_q  <= 1'b0;
    end else begin
      v1_q    <= bus.in_valid;
      s1_q    <= bus.s;
      sinv1_q <= bus.s_invert;
      papb1_q <= bus.papb;
      pab1_q  <= bus.pab;
    end
  end

  // Any bit where the true rail equals the complement rail is a duplication fault.
  always_comb begin
    dup1 = v1_q & (|(s1_q ~^ sinv1_q));
    par1 = v1_q & (papb1_q ^ pab1_q);
    err1 = dup1 | par1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clear) begin
      cnt_d = '0;
    end else if (err1 && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MON:     if (!bus.clear && (cnt_d >= TH)) state_d = ALARM;
      ALARM:   if (bus.clear) state_d = MON;
      default: state_d = MON;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q    <= 1'b0;
      dup_q   <= 1'b0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= MON;
    end else begin
      ev_q    <= v1_q;
      dup_q   <= dup1;
      par_q   <= par1;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign bus.err_valid = ev_q;
  assign bus.err_dup   = dup_q;
  assign bus.err_par   = par_q;
  assign bus.err_cnt   = cnt_q;
  assign bus.alarm     = (state_q == ALARM);

`ifdef ERR_LOG_EN
  logic             log_valid_q;
  logic [WIDTH-1:0] log_s_q;
  logic [1:0]       log_syn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_valid_q <= 1'b0;
      log_s_q     <= '0;
      log_syn_q   <= '0;
    end else if (bus.clear) begin
      log_valid_q <= 1'b0;
      log_s_q     <= '0;
      log_syn_q   <= '0;
    end else if (err1 && !log_valid_q) begin
      log_valid_q <= 1'b1;
      log_s_q     <= s1_q;
      log_syn_q   <= {dup1, par1};
    end
  end

  assign bus.log_valid = log_valid_q;
  assign bus.log_s     = log_s_q;
  assign bus.log_syn   = log_syn_q;
`endif

endmodule

// File: tb/tb_adder64_error_checker.sv
// Directed/self-checking bench for adder64_error_checker: main instance (CNT_W=8, ALARM_TH=4)
// plus a narrow-counter instance (CNT_W=2, ALARM_TH=3) for saturation.
module tb_adder64_error_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  adder64_error_checker_if #(.WIDTH(64), .CNT_W(8)) bus_m ();
  adder64_error_checker_if #(.WIDTH(64), .CNT_W(2)) bus_s ();

  adder64_error_checker #(.WIDTH(64), .CNT_W(8), .ALARM_TH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_m.slave)
  );
  adder64_error_checker #(.WIDTH(64), .CNT_W(2), .ALARM_TH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s.slave)
  );

  task automatic drive(input logic v, input logic [63:0] sv, input logic [63:0] si,
                       input logic pp, input logic pa);
    bus_m.in_valid = v;  bus_m.s = sv;  bus_m.s_invert = si;  bus_m.papb = pp;  bus_m.pab = pa;
    bus_s.in_valid = v;  bus_s.s = sv;  bus_s.s_invert = si;  bus_s.papb = pp;  bus_s.pab = pa;
  endtask

  task automatic set_clear(input logic c);
    bus_m.clear = c;
    bus_s.clear = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus_m.err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got=%b exp=0", bus_m.err_valid); end
    checks++; if (bus_m.err_dup !== 1'b0) begin errors++; $display("FAIL reset_err_dup got=%b exp=0", bus_m.err_dup); end
    checks++; if (bus_m.err_par !== 1'b0) begin errors++; $display("FAIL reset_err_par got=%b exp=0", bus_m.err_par); end
    checks++; if (bus_m.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", bus_m.err_cnt); end
    checks++; if (bus_m.alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b exp=0", bus_m.alarm); end
`ifdef ERR_LOG_EN
    checks++; if (bus_m.log_valid !== 1'b0) begin errors++; $display("FAIL reset_log_valid got=%b exp=0", bus_m.log_valid); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    logic prev_v = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] a, b, sum;
      logic v, p;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      sum = a + b;
      v = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      drive(v, sum, ~sum, p, p);
      step();
      checks++; if (bus_m.err_valid !== prev_v) begin errors++; $display("FAIL clean_err_valid i=%0d got=%b exp=%b", i, bus_m.err_valid, prev_v); end
      checks++; if ({bus_m.err_dup, bus_m.err_par} !== 2'b00) begin errors++; $display("FAIL clean_err_flags i=%0d got=%b%b exp=00", i, bus_m.err_dup, bus_m.err_par); end
      prev_v = v;
    end
    drive(1'b0, '0, '1, 1'b0, 1'b0);
    step();
    step();
    checks++; if (bus_m.err_cnt !== 8'd0) begin errors++; $display("FAIL clean_err_cnt got=%0d exp=0", bus_m.err_cnt); end
    checks++; if (bus_m.alarm !== 1'b0) begin errors++; $display("FAIL clean_alarm got=%b exp=0", bus_m.alarm); end
  endtask

  task automatic test_dup();
    drive(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '1, 1'b0, 1'b0);
    step();
    checks++; if (bus_m.err_valid !== 1'b1) begin errors++; $display("FAIL dup_err_valid got=%b exp=1", bus_m.err_valid); end
    checks++; if ({bus_m.err_dup, bus_m.err_par} !== 2'b10) begin errors++; $display("FAIL dup_flags got=%b%b exp=10", bus_m.err_dup, bus_m.err_par); end
    checks++; if (bus_m.err_cnt !== 8'd1) begin errors++; $display("FAIL dup_err_cnt got=%0d exp=1", bus_m.err_cnt); end
    step();
    checks++; if ({bus_m.err_valid, bus_m.err_dup} !== 2'b00) begin errors++; $display("FAIL dup_idle_flags got=%b%b exp=00", bus_m.err_valid, bus_m.err_dup); end
    set_clear(1'b1);
    step();
    set_clear(1'b0);
    checks++; if (bus_m.err_cnt !== 8'd0) begin errors++; $display("FAIL dup_clear_cnt got=%0d exp=0", bus_m.err_cnt); end
  endtask

  task automatic test_parity_alarm();
    for (int i = 0; i < 9; i++) begin
      int unsigned exp_cnt;
      if (i < 4) drive(1'b1, 64'hA5A5, ~64'hA5A5, 1'b1, 1'b0);
      else       drive(1'b1, 64'h1111, ~64'h1111, 1'b1, 1'b1);
      step();
      if (i >= 1) begin
        exp_cnt = (i > 4) ? 4 : i;
        checks++; if (bus_m.err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL par_err_cnt i=%0d got=%0d exp=%0d", i, bus_m.err_cnt, exp_cnt); end
        checks++; if (bus_m.alarm !== (i >= 4)) begin errors++; $display("FAIL par_alarm i=%0d got=%b exp=%b", i, bus_m.alarm, (i >= 4)); end
        checks++; if (bus_m.err_par !== (i <= 4)) begin errors++; $display("FAIL par_flag i=%0d got=%b exp=%b", i, bus_m.err_par, (i <= 4)); end
      end
    end
  endtask

  task automatic test_clear_priority();
    drive(1'b1, 64'h5, 64'h5, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '1, 1'b0, 1'b0);
    set_clear(1'b1);
    step();
    set_clear(1'b0);
    checks++; if ({bus_m.err_valid, bus_m.err_dup, bus_m.err_par} !== 3'b111) begin errors++; $display("FAIL clrpri_flags got=%b%b%b exp=111", bus_m.err_valid, bus_m.err_dup, bus_m.err_par); end
    checks++; if (bus_m.err_cnt !== 8'd0) begin errors++; $display("FAIL clrpri_err_cnt got=%0d exp=0", bus_m.err_cnt); end
    checks++; if (bus_m.alarm !== 1'b0) begin errors++; $display("FAIL clrpri_alarm got=%b exp=0", bus_m.alarm); end
  endtask

  task automatic test_saturation();
    set_clear(1'b1);
    step();
    set_clear(1'b0);
    checks++; if (bus_s.err_cnt !== 2'd0) begin errors++; $display("FAIL sat_cleared got=%0d exp=0", bus_s.err_cnt); end
    for (int i = 0; i < 6; i++) begin
      int unsigned exp_sat;
      if (i < 5) drive(1'b1, 64'hF0, ~64'hF0, 1'b0, 1'b1);
      else       drive(1'b0, '0, '1, 1'b0, 1'b0);
      step();
      if (i >= 1) begin
        exp_sat = (i > 3) ? 3 : i;
        checks++; if (bus_s.err_cnt !== 2'(exp_sat)) begin errors++; $display("FAIL sat_err_cnt i=%0d got=%0d exp=%0d", i, bus_s.err_cnt, exp_sat); end
        checks++; if (bus_s.alarm !== (i >= 3)) begin errors++; $display("FAIL sat_alarm i=%0d got=%b exp=%b", i, bus_s.alarm, (i >= 3)); end
        checks++; if (bus_m.err_cnt !== 8'(i)) begin errors++; $display("FAIL sat_main_cnt i=%0d got=%0d exp=%0d", i, bus_m.err_cnt, i); end
      end
    end
  endtask

  task automatic test_reset_midburst();
    set_clear(1'b1);
    step();
    set_clear(1'b0);
    drive(1'b1, 64'h7, 64'h7, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h9, ~64'h9, 1'b1, 1'b0);
    step();
    checks++; if ({bus_m.err_valid, bus_m.err_dup, bus_m.err_cnt} !== {2'b11, 8'd1}) begin errors++; $display("FAIL burst_pre got=%b%b cnt=%0d exp=11 cnt=1", bus_m.err_valid, bus_m.err_dup, bus_m.err_cnt); end
    drive(1'b1, 64'hB, 64'hB, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus_m.err_valid, bus_m.err_dup, bus_m.err_par, bus_m.alarm} !== 4'b0000) begin errors++; $display("FAIL burst_async_flags got=%b%b%b%b exp=0000", bus_m.err_valid, bus_m.err_dup, bus_m.err_par, bus_m.alarm); end
    checks++; if (bus_m.err_cnt !== 8'd0) begin errors++; $display("FAIL burst_async_cnt got=%0d exp=0", bus_m.err_cnt); end
    drive(1'b0, '0, '1, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({bus_m.err_valid, bus_m.err_cnt} !== {1'b0, 8'd0}) begin errors++; $display("FAIL burst_after_release i=%0d got=%b cnt=%0d exp=0 cnt=0", i, bus_m.err_valid, bus_m.err_cnt); end
    end
  endtask

`ifdef ERR_LOG_EN
  task automatic test_log();
    drive(1'b1, 64'h1234, 64'h1234, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h5678, ~64'h5678, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '1, 1'b0, 1'b0);
    step();
    step();
    checks++; if (bus_m.log_valid !== 1'b1) begin errors++; $display("FAIL log_valid got=%b exp=1", bus_m.log_valid); end
    checks++; if (bus_m.log_s !== 64'h1234) begin errors++; $display("FAIL log_s got=%h exp=1234", bus_m.log_s); end
    checks++; if (bus_m.log_syn !== 2'b10) begin errors++; $display("FAIL log_syn got=%b exp=10", bus_m.log_syn); end
    set_clear(1'b1);
    step();
    set_clear(1'b0);
    checks++; if ({bus_m.log_valid, bus_m.log_syn} !== 3'b000 || bus_m.log_s !== 64'h0) begin errors++; $display("FAIL log_clear got=%b %b %h exp=0 00 0", bus_m.log_valid, bus_m.log_syn, bus_m.log_s); end
  endtask
`endif

  initial begin
    drive(1'b0, '0, '1, 1'b0, 1'b0);
    set_clear(1'b0);
    #1;
    test_reset();
    test_clean();
    test_dup();
    test_parity_alarm();
    test_clear_priority();
    test_saturation();
    test_reset_midburst();
`ifdef ERR_LOG_EN
    test_log();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
